// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: captures code and guesses peg-by-peg, hands each
// full guess to the scorer via start/done, latches feedback, tracks turns and
// decides win/loss.
// Optional scorer watchdog: define MASTERMIND_SCORE_TIMEOUT_EN.
//
// state        | meaning
// CODE_ENTRY   | capturing secret code pegs
// GUESS_ENTRY  | capturing guess pegs
// SCORE_REQ    | one-cycle start request to scorer
// SCORE_WAIT   | waiting for scorer done (or watchdog expiry)
// WON          | guess fully matched, hold until new_game
// LOST         | turns exhausted, hold until new_game
module mastermind_game_ctrl #(
    parameter int MAX_GUESSES    = 8,
    parameter int PEGS           = 4,
    parameter int COLOR_W        = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      load,
    input  logic                      new_game,
    input  logic [COLOR_W-1:0]        peg_in,
    input  logic                      score_done,
    input  logic [2:0]                score_red,
    input  logic [2:0]                score_white,
    output logic                      score_start,
    output logic [PEGS*COLOR_W-1:0]   code,
    output logic [PEGS*COLOR_W-1:0]   guess,
    output logic [2:0]                red_out,
    output logic [2:0]                white_out,
    output logic [3:0]                turn,
    output logic [1:0]                peg_idx,
    output logic [2:0]                state,
    output logic                      game_won,
    output logic                      game_lost,
    output logic                      score_err
);

    typedef enum logic [2:0] {
        CODE_ENTRY  = 3'd0,
        GUESS_ENTRY = 3'd1,
        SCORE_REQ   = 3'd2,
        SCORE_WAIT  = 3'd3,
        WON         = 3'd4,
        LOST        = 3'd5
    } state_t;

    localparam logic [3:0] MAX_T  = 4'(MAX_GUESSES);
    localparam logic [2:0] PEGS_R = 3'(PEGS);

    state_t                    state_q, state_d;
    logic [PEGS*COLOR_W-1:0]   code_q, code_d, guess_q, guess_d;
    logic [2:0]                red_q, red_d, white_q, white_d;
    logic [3:0]                turn_q, turn_d;
    logic [1:0]                peg_idx_q, peg_idx_d;
    logic                      load_q;
    logic                      start_q, start_d;
    logic                      capture;
    logic                      wd_expired;

    assign capture = load & ~load_q;

    // State and datapath registers; load_q resets high so a held button is not a capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= CODE_ENTRY;
            code_q    <= '0;
            guess_q   <= '0;
            red_q     <= '0;
            white_q   <= '0;
            turn_q    <= '0;
            peg_idx_q <= '0;
            load_q    <= 1'b1;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            guess_q   <= guess_d;
            red_q     <= red_d;
            white_q   <= white_d;
            turn_q    <= turn_d;
            peg_idx_q <= peg_idx_d;
            load_q    <= load;
            start_q   <= start_d;
        end
    end

    // Next-state and register updates; new_game overrides captures and score_done
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        guess_d   = guess_q;
        red_d     = red_q;
        white_d   = white_q;
        turn_d    = turn_q;
        peg_idx_d = peg_idx_q;
        if (new_game) begin
            state_d   = CODE_ENTRY;
            code_d    = '0;
            guess_d   = '0;
            red_d     = '0;
            white_d   = '0;
            turn_d    = '0;
            peg_idx_d = '0;
        end else begin
            case (state_q)
                CODE_ENTRY: begin
                    if (capture) begin
                        code_d[peg_idx_q*COLOR_W +: COLOR_W] = peg_in;
                        peg_idx_d = peg_idx_q + 2'd1;
                        if (peg_idx_q == 2'd3) state_d = GUESS_ENTRY;
                    end
                end
                GUESS_ENTRY: begin
                    if (capture) begin
                        guess_d[peg_idx_q*COLOR_W +: COLOR_W] = peg_in;
                        peg_idx_d = peg_idx_q + 2'd1;
                        if (peg_idx_q == 2'd3) state_d = SCORE_REQ;
                    end
                end
                SCORE_REQ: state_d = SCORE_WAIT;
                SCORE_WAIT: begin
                    if (score_done) begin
                        red_d   = score_red;
                        white_d = score_white;
                        turn_d  = turn_q + 4'd1;
                        if (score_red == PEGS_R)
                            state_d = WON;
                        else if (turn_q + 4'd1 == MAX_T)
                            state_d = LOST;
                        else
                            state_d = GUESS_ENTRY;
                    end else if (wd_expired) begin
                        state_d = GUESS_ENTRY;
                    end
                end
                WON, LOST: ;
                default: state_d = CODE_ENTRY;
            endcase
        end
        start_d = (state_d == SCORE_REQ);
    end

`ifdef MASTERMIND_SCORE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;

    assign wd_expired = (wd_q == '0);

    // Watchdog down-counter armed in SCORE_REQ, terminal count reached after TIMEOUT_CYCLES waits
    always_comb begin
        wd_d  = wd_q;
        err_d = err_q;
        if (state_q == SCORE_REQ)
            wd_d = CNT_W'(TIMEOUT_CYCLES - 1);
        else if (state_q == SCORE_WAIT && wd_q != '0)
            wd_d = wd_q - CNT_W'(1);
        if (new_game)
            err_d = 1'b0;
        else if (state_q == SCORE_WAIT && !score_done && wd_expired)
            err_d = 1'b1;
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign score_err = err_q;
`else
    assign wd_expired = 1'b0;
    assign score_err  = 1'b0;
`endif

    assign score_start = start_q;
    assign code        = code_q;
    assign guess       = guess_q;
    assign red_out     = red_q;
    assign white_out   = white_q;
    assign turn        = turn_q;
    assign peg_idx     = peg_idx_q;
    assign state       = state_q;
    assign game_won    = (state_q == WON);
    assign game_lost   = (state_q == LOST);

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Randomized scoreboard bench for mastermind_game_ctrl.
module tb_mastermind_game_ctrl;

    localparam int MAXG = 8;
    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        load = 1'b0;
    logic        new_game = 1'b0;
    logic [2:0]  peg_in = '0;
    logic        score_done = 1'b0;
    logic [2:0]  score_red = '0;
    logic [2:0]  score_white = '0;
    logic        score_start;
    logic [11:0] code, guess;
    logic [2:0]  red_out, white_out;
    logic [3:0]  turn;
    logic [1:0]  peg_idx;
    logic [2:0]  state;
    logic        game_won, game_lost, score_err;

    mastermind_game_ctrl #(
        .MAX_GUESSES(MAXG), .PEGS(4), .COLOR_W(3), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .resetn(resetn), .load(load), .new_game(new_game),
        .peg_in(peg_in), .score_done(score_done), .score_red(score_red),
        .score_white(score_white), .score_start(score_start), .code(code),
        .guess(guess), .red_out(red_out), .white_out(white_out), .turn(turn),
        .peg_idx(peg_idx), .state(state), .game_won(game_won),
        .game_lost(game_lost), .score_err(score_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] c;
        logic [11:0] g;
    } req_t;

    typedef struct {
        int red;
        int white;
        int trn;
        int won;
        int lost;
        int st;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];

    int vectors = 0;
    int miscompares = 0;

    // reference model of the game, kept in spec terms
    logic [11:0] m_code = '0;
    int m_red = 0, m_white = 0, m_turn = 0, m_state = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // classic Mastermind scoring: exact matches, then colour-multiset overlap
    task automatic ref_score(input logic [11:0] c, input logic [11:0] g,
                             output int r, output int w);
        int cc[8];
        int gc[8];
        for (int k = 0; k < 8; k++) begin cc[k] = 0; gc[k] = 0; end
        r = 0;
        w = 0;
        for (int i = 0; i < 4; i++) begin
            if (c[i*3 +: 3] == g[i*3 +: 3]) r++;
            cc[c[i*3 +: 3]]++;
            gc[g[i*3 +: 3]]++;
        end
        for (int k = 0; k < 8; k++) w += (cc[k] < gc[k]) ? cc[k] : gc[k];
        w -= r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] c);
        peg_in = c;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic push_exp();
        res_t e;
        e.red = m_red; e.white = m_white; e.trn = m_turn;
        e.won = (m_state == 4) ? 1 : 0;
        e.lost = (m_state == 5) ? 1 : 0;
        e.st = m_state;
        res_q.push_back(e);
    endtask

    task automatic enter_code(input logic [11:0] c);
        for (int i = 0; i < 4; i++) press(c[i*3 +: 3]);
        m_code = c;
        m_state = 1;
        chk("code_val", int'(code), int'(c));
        chk("code_state", int'(state), 1);
        chk("code_idx", int'(peg_idx), 0);
    endtask

    task automatic enter_guess(input logic [11:0] g);
        req_t rq;
        rq.c = m_code;
        rq.g = g;
        req_q.push_back(rq);
        for (int i = 0; i < 4; i++) press(g[i*3 +: 3]);
        chk("wait_state", int'(state), 3);
    endtask

    task automatic play_turn(input logic [11:0] g, input bit forced,
                             input int fr, input int fw, input int dly);
        int r, w;
        enter_guess(g);
        repeat (dly) tick();
        if (forced) begin r = fr; w = fw; end
        else ref_score(m_code, g, r, w);
        m_red = r;
        m_white = w;
        m_turn++;
        if (r == 4) m_state = 4;
        else if (m_turn == MAXG) m_state = 5;
        else m_state = 1;
        score_done = 1'b1;
        score_red = 3'(r);
        score_white = 3'(w);
        push_exp();
        tick();
        score_done = 1'b0;
        score_red = 3'($urandom);
        score_white = 3'($urandom);
    endtask

    task automatic restart();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        m_code = '0; m_red = 0; m_white = 0; m_turn = 0; m_state = 0;
        chk("ng_state", int'(state), 0);
        chk("ng_code", int'(code), 0);
        chk("ng_guess", int'(guess), 0);
        chk("ng_turn", int'(turn), 0);
        chk("ng_red", int'(red_out), 0);
        chk("ng_err", int'(score_err), 0);
    endtask

    // monitor: pops the expected guess on each start pulse and the expected
    // feedback one cycle after every score_done pulse
    initial begin : monitor
        bit done_seen = 1'b0;
        bit start_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (score_start) begin
                    chk("start_single", int'(start_prev), 0);
                    if (req_q.size() == 0) begin
                        chk("start_unexpected", 1, 0);
                    end else begin
                        req_t rq;
                        rq = req_q.pop_front();
                        chk("start_code", int'(code), int'(rq.c));
                        chk("start_guess", int'(guess), int'(rq.g));
                    end
                end
                if (done_seen) begin
                    if (res_q.size() == 0) begin
                        chk("result_unexpected", 1, 0);
                    end else begin
                        res_t e;
                        e = res_q.pop_front();
                        chk("res_red", int'(red_out), e.red);
                        chk("res_white", int'(white_out), e.white);
                        chk("res_turn", int'(turn), e.trn);
                        chk("res_won", int'(game_won), e.won);
                        chk("res_lost", int'(game_lost), e.lost);
                        chk("res_state", int'(state), e.st);
                    end
                end
            end
            done_seen = score_done && resetn;
            start_prev = score_start && resetn;
        end
    end

    initial begin : stimulus
        logic [11:0] c, g;
        int guard;

        // reset values, with load held high across reset release
        load = 1'b1;
        repeat (3) tick();
        chk("rst_state", int'(state), 0);
        chk("rst_code", int'(code), 0);
        chk("rst_turn", int'(turn), 0);
        chk("rst_start", int'(score_start), 0);
        chk("rst_won_lost", int'({game_won, game_lost}), 0);
        resetn = 1'b1;
        tick();
        tick();
        chk("held_load_idx", int'(peg_idx), 0);
        chk("held_load_code", int'(code), 0);
        load = 1'b0;
        tick();

        // directed code entry 1,2,3,4
        press(3'd1);
        press(3'd2);
        chk("code_mid_idx", int'(peg_idx), 2);
        press(3'd3);
        press(3'd4);
        chk("code_directed", int'(code), 12'b100_011_010_001);
        chk("code_dir_state", int'(state), 1);
        chk("code_dir_idx", int'(peg_idx), 0);
        m_code = 12'b100_011_010_001;
        m_state = 1;

        // stray score_done in GUESS_ENTRY changes nothing
        score_done = 1'b1;
        score_red = 3'd4;
        push_exp();
        tick();
        score_done = 1'b0;
        tick();

        // winning first turn, then loads are ignored
        play_turn(m_code, 1'b0, 0, 0, 1);
        press(3'd5);
        press(3'd6);
        chk("won_hold_state", int'(state), 4);
        chk("won_hold_guess", int'(guess), int'(m_code));
        chk("won_hold_idx", int'(peg_idx), 0);

        // losing game: every turn scored red=1 white=2
        restart();
        c = 12'($urandom);
        enter_code(c);
        for (int t = 0; t < MAXG; t++)
            play_turn(12'($urandom), 1'b1, 1, 2, $urandom_range(0, 3));
        chk("lost_turn", int'(turn), MAXG);
        chk("lost_flag", int'(game_lost), 1);
        press(3'd2);
        chk("lost_hold_idx", int'(peg_idx), 0);

        // win on the final turn takes priority over loss
        restart();
        enter_code(12'($urandom));
        for (int t = 0; t < MAXG - 1; t++)
            play_turn(12'($urandom), 1'b1, 1, 2, 0);
        play_turn(m_code, 1'b0, 0, 0, 2);
        chk("final_won", int'(game_won), 1);
        chk("final_lost", int'(game_lost), 0);

        // random games scored by the reference model
        for (int gm = 0; gm < 6; gm++) begin
            restart();
            enter_code(12'($urandom));
            guard = 0;
            while (m_state == 1 && guard < 20) begin
                g = ($urandom_range(0, 4) == 0) ? m_code : 12'($urandom);
                play_turn(g, 1'b0, 0, 0, $urandom_range(0, 3));
                guard++;
            end
        end

        // new_game beats a same-cycle score_done
        restart();
        enter_code(12'($urandom));
        play_turn(12'($urandom), 1'b1, 2, 1, 0);
        enter_guess(12'($urandom));
        new_game = 1'b1;
        score_done = 1'b1;
        score_red = 3'd4;
        m_code = '0; m_red = 0; m_white = 0; m_turn = 0; m_state = 0;
        push_exp();
        tick();
        new_game = 1'b0;
        score_done = 1'b0;
        chk("prio_code", int'(code), 0);
        tick();

        // silent scorer
        enter_code(12'($urandom));
        play_turn(12'($urandom), 1'b1, 0, 3, 1);
        enter_guess(12'($urandom));
        repeat (TOUT - 1) tick();
        chk("wd_early_state", int'(state), 3);
        chk("wd_early_err", int'(score_err), 0);
        tick();
`ifdef MASTERMIND_SCORE_TIMEOUT_EN
        chk("wd_err", int'(score_err), 1);
        chk("wd_state", int'(state), 1);
`else
        chk("wd_err_off", int'(score_err), 0);
        chk("wd_state_off", int'(state), 3);
`endif
        chk("wd_turn", int'(turn), 1);
        chk("wd_white", int'(white_out), 3);
        repeat (4) tick();
        restart();
        tick();

        chk("req_queue_empty", req_q.size(), 0);
        chk("res_queue_empty", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mastermind_game_ctrl.md
# mastermind_game_ctrl

Game-level sequencer for the Mastermind board. It captures the secret code and each guess peg-by-peg from the switches, then hands the completed guess to the peg-scoring datapath through a start/done handshake. It latches the red/white feedback, counts turns, and decides win or loss. It sits between the KEY/SW inputs and the scorer, and its outputs drive the HEX displays.

## Interface
- `MAX_GUESSES`, default 8: turns allowed per game, legal range 1..15.
- `PEGS`, default 4: pegs per code. Fixed at 4; `peg_idx` is 2 bits wide.
- `COLOR_W`, default 3: bits per peg colour.
- `TIMEOUT_CYCLES`, default 16: scorer watchdog limit. Used only when `MASTERMIND_SCORE_TIMEOUT_EN` is defined.
- `clk` in 1: system clock (CLOCK_50 at top level).
- `resetn` in 1: reset, asynchronous, active-low.
- `load` in 1: level from the inverted KEY[0], active-high.
- `new_game` in 1: synchronous restart request, active-high.
- `peg_in` in COLOR_W: colour on SW.
- `score_done` in 1: single-cycle pulse from the scorer.
- `score_red` in 3: scorer red count. Valid when `score_done`=1.
- `score_white` in 3: scorer white count. Valid when `score_done`=1.
- `score_start` out 1: one-cycle request to the scorer.
- `code` out PEGS*COLOR_W: secret code. Peg 0 is in bits [2:0].
- `guess` out PEGS*COLOR_W: current guess, same packing as `code`.
- `red_out` out 3: last latched red count.
- `white_out` out 3: last latched white count.
- `turn` out 4: number of scored guesses this game.
- `peg_idx` out 2: index of the next peg to be written.
- `state` out 3: FSM state encoding.
- `game_won` out 1: high while in WON.
- `game_lost` out 1: high while in LOST.
- `score_err` out 1: watchdog flag. Tied to 0 when the macro is off.

## Operation
- Load edge detection:
  - `load_q` registers `load`.
  - A capture event occurs when `load` is 1 and `load_q` is 0.
  - `load_q` resets to 1, so a button held through reset release does not produce a capture.
- FSM states and encoding:
  - CODE_ENTRY = 0
  - GUESS_ENTRY = 1
  - SCORE_REQ = 2
  - SCORE_WAIT = 3
  - WON = 4
  - LOST = 5
  - Encodings 6 and 7 are illegal and go to CODE_ENTRY.
- CODE_ENTRY:
  - Each capture writes `peg_in` into `code` at `peg_idx`, then increments `peg_idx`.
  - The capture at `peg_idx`=3 wraps `peg_idx` to 0 and moves to GUESS_ENTRY.
- GUESS_ENTRY:
  - Captures fill `guess` the same way.
  - The capture at `peg_idx`=3 wraps `peg_idx` to 0 and moves to SCORE_REQ.
- SCORE_REQ: `score_start`=1 for exactly this one cycle, then unconditionally moves to SCORE_WAIT.
- SCORE_WAIT: waits for `score_done`. When it arrives:
  - `red_out` and `white_out` latch the scorer counts.
  - `turn` increments.
  - If `score_red` equals PEGS, go to WON.
  - Otherwise, if `turn`+1 equals MAX_GUESSES, go to LOST.
  - Otherwise, go to GUESS_ENTRY.
  - WON takes priority over LOST on the final turn.
- WON and LOST hold all registers until `new_game`.
- Captures are ignored in SCORE_REQ, SCORE_WAIT, WON and LOST. `load_q` still tracks `load` in these states.
- `score_done` is ignored outside SCORE_WAIT.
- `new_game` in any state, on the next edge:
  - Go to CODE_ENTRY.
  - Clear `code`, `guess`, `red_out`, `white_out`, `turn`, `peg_idx` and `score_err`.
  - `new_game` has priority over a same-cycle capture or `score_done`.
- `red_out` and `white_out` keep their previous values while the next guess is entered.
- Width rules:
  - `turn` never exceeds MAX_GUESSES.
  - `score_red` and `score_white` are taken unchecked.

## Timing
- Reset values:
  - `state` = CODE_ENTRY
  - `code`, `guess` = 0
  - `red_out`, `white_out` = 0
  - `turn`, `peg_idx` = 0
  - `score_start`, `game_won`, `game_lost`, `score_err` = 0
  - `load_q` = 1
- An edge detected in cycle N shows the updated peg on the outputs in cycle N+1.
- For the 4th guess peg captured in cycle N:
  - `score_start` is high in cycle N+1.
  - SCORE_WAIT begins in cycle N+2.
  - The earliest usable `score_done` is in cycle N+2.
- `score_done` in cycle M: `red_out`, `white_out`, `turn`, `state`, `game_won` and `game_lost` update in cycle M+1.
- Minimum turn time from last peg to the next GUESS_ENTRY is 3 cycles.
- All outputs are registered except `game_won` and `game_lost`, which are decoded from `state`.
- Asserting `resetn` low mid-score:
  - Immediately returns everything to the reset values.
  - `score_start` drops asynchronously.
  - The scorer must be reset by the same `resetn`.

## Configuration
- Macro: `MASTERMIND_SCORE_TIMEOUT_EN`.
- When defined:
  - A cycle counter runs in SCORE_WAIT.
  - If `score_done` has not arrived after TIMEOUT_CYCLES cycles, `score_err` is set to 1 and the FSM returns to GUESS_ENTRY.
  - The timed-out guess does not consume a turn; `turn`, `red_out` and `white_out` are unchanged.
  - `score_err` stays set until `new_game` or reset.
- When undefined:
  - SCORE_WAIT waits indefinitely.
  - `score_err` is constant 0 and no counter logic is present.

## Test plan
- Code entry:
  - Stimulus: reset, then four `load` pulses with `peg_in` = 1, 2, 3, 4.
  - Required: `code` = 12'b100_011_010_001, `state` = 1, `peg_idx` = 0.
  - Also hold `load` high across reset release; required: no capture.
- Winning turn:
  - Stimulus: enter a guess, scorer model returns `score_done` with red=4, white=0.
  - Required: `score_start` is exactly one pulse; one cycle after `score_done`, `red_out` = 4, `turn` = 1, `game_won` = 1; further loads are ignored.
- Losing game:
  - Stimulus: MAX_GUESSES=8, eight guesses each scored red=1, white=2.
  - Required: after the 8th guess, `turn` = 8 and `game_lost` = 1.
  - Also score red=4 on the 8th turn; required: `game_won` = 1, `game_lost` = 0.
- Priority:
  - Stimulus: `new_game` asserted in the same cycle as `score_done` in SCORE_WAIT.
  - Required: `state` = 0, `turn` = 0, `red_out` = 0.
  - Also a `score_done` pulse in GUESS_ENTRY; required: no change.
- Watchdog:
  - Stimulus: macro defined, TIMEOUT_CYCLES=16, scorer silent.
  - Required: 16 cycles into SCORE_WAIT, `score_err` = 1, `state` = 1, `turn` unchanged.
  - Same stimulus with the macro undefined; required: remains in `state` = 3.
